// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the master-port arbiter and its bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin pick: first active request after ptr_i, wrapping.
module ahb_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port among NREQ requesters with round-robin
// arbitration, pipelined address/data phases and two-cycle ERROR recovery.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*3-1:0] req_size,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic [AW-1:0]     haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic              hwrite,
    output logic [DW-1:0]     hwdata,
    input  logic [DW-1:0]     hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] PTR_RESET = IW'(NREQ - 1);

    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic [2:0]    hsize_q, hsize_d;
    logic          hwrite_q, hwrite_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    logic [DW-1:0] aph_wdata_q, aph_wdata_d;
    logic [IW-1:0] aph_owner_q, aph_owner_d;
    logic          dph_valid_q, dph_valid_d;
    logic [IW-1:0] dph_owner_q, dph_owner_d;
    logic          cancel_q, cancel_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic            arb_en;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;

    // While a cancelled command waits to be re-driven the address slot is reserved.
    assign arb_en = hready && !cancel_q;

    ahb_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    assign req_ready = grant;

    always_comb begin
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        aph_wdata_d = aph_wdata_q;
        aph_owner_d = aph_owner_q;
        dph_valid_d = dph_valid_q;
        dph_owner_d = dph_owner_q;
        cancel_d    = cancel_q;
        ptr_d       = ptr_q;

        if (hready) begin
            if (cancel_q) begin
                htrans_d = HTRANS_NONSEQ;
                cancel_d = 1'b0;
            end else if (|grant) begin
                haddr_d     = req_addr[win_idx*AW +: AW];
                hsize_d     = req_size[win_idx*3 +: 3];
                hwrite_d    = req_write[win_idx];
                aph_wdata_d = req_wdata[win_idx*DW +: DW];
                aph_owner_d = win_idx;
                htrans_d    = HTRANS_NONSEQ;
                ptr_d       = win_idx;
            end else begin
                htrans_d = HTRANS_IDLE;
            end

            if (htrans_q == HTRANS_NONSEQ) begin
                dph_valid_d = 1'b1;
                dph_owner_d = aph_owner_q;
                if (hwrite_q) begin
                    hwdata_d = aph_wdata_q;
                end
            end else begin
                dph_valid_d = 1'b0;
            end
        end else if (hresp == HRESP_ERROR && dph_valid_q && htrans_q == HTRANS_NONSEQ) begin
            // First ERROR cycle: withdraw the pending address, keep its contents for replay.
            htrans_d = HTRANS_IDLE;
            cancel_d = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (dph_valid_q && hready) begin
            rsp_valid[dph_owner_q] = 1'b1;
        end
    end

    assign rsp_err   = dph_valid_q && hready && hresp;
    assign rsp_rdata = hrdata;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            aph_wdata_q <= '0;
            aph_owner_q <= '0;
            dph_valid_q <= 1'b0;
            dph_owner_q <= '0;
            cancel_q    <= 1'b0;
            ptr_q       <= PTR_RESET;
        end else begin
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            aph_wdata_q <= aph_wdata_d;
            aph_owner_q <= aph_owner_d;
            dph_valid_q <= dph_valid_d;
            dph_owner_q <= dph_owner_d;
            cancel_q    <= cancel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign haddr  = haddr_q;
    assign htrans = htrans_q;
    assign hsize  = hsize_q;
    assign hwrite = hwrite_q;
    assign hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with two requesters and a scripted slave.
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              hclk = 1'b0;
    logic              hreset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*3-1:0] req_size;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     haddr;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [DW-1:0]     hwdata;
    logic [DW-1:0]     hrdata;
    logic              hready;
    logic              hresp;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_master_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .haddr     (haddr),
        .htrans    (htrans),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic w,
                           input logic [2:0] s, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_addr[i*AW +: AW]   = a;
        req_write[i]           = w;
        req_size[i*3 +: 3]     = s;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset    = 1'b1;
        req_valid = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        @(negedge hclk);
        hreset = 1'b0;
        step();
    endtask

    logic [1:0]    g2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [DW-1:0] rd2[4] = '{32'h11, 32'h22, 32'h11, 32'h22};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_size  = '0;
        req_wdata = '0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        #3;
        check("rst_htrans", htrans, HTRANS_IDLE);
        check("rst_haddr", haddr, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_hsize", hsize, 0);
        check("rst_hwrite", hwrite, 0);
        check("rst_rsp_valid", rsp_valid, 0);

        // Single write with zero wait states
        @(negedge hclk);
        hreset = 1'b0;
        step();
        set_req(0, 1'b1, 32'h100, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
        #1;
        check("t1_ready", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        #1;
        check("t1_htrans", htrans, HTRANS_NONSEQ);
        check("t1_haddr", haddr, 32'h100);
        check("t1_hwrite", hwrite, 1);
        check("t1_hsize", hsize, HSIZE_WORD);
        check("t1_rsp_early", rsp_valid, 0);
        step();
        check("t1_hwdata", hwdata, 32'hDEADBEEF);
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_htrans_idle", htrans, HTRANS_IDLE);
        step();
        check("t1_rsp_done", rsp_valid, 0);

        // Back-to-back reads from both requesters alternate grants
        do_reset();
        set_req(0, 1'b1, 32'h10, 1'b0, HSIZE_WORD, 32'h0);
        set_req(1, 1'b1, 32'h20, 1'b0, HSIZE_WORD, 32'h0);
        for (int c = 0; c < 6; c++) begin
            if (c == 4) req_valid = '0;
            if (c >= 2) hrdata = rd2[c-2];
            #1;
            if (c < 4) check("t2_ready", req_ready, g2[c]);
            else       check("t2_ready_idle", req_ready, 0);
            if (c >= 1 && c <= 4) check("t2_haddr", haddr, (g2[c-1] == 2'b01) ? 32'h10 : 32'h20);
            if (c >= 2) begin
                check("t2_rsp_valid", rsp_valid, g2[c-2]);
                check("t2_rsp_rdata", rsp_rdata, rd2[c-2]);
            end else begin
                check("t2_rsp_none", rsp_valid, 0);
            end
            step();
        end

        // Three wait states on a read with the next command in address phase
        set_req(0, 1'b1, 32'h200, 1'b0, HSIZE_WORD, 32'h0);
        set_req(1, 1'b1, 32'h204, 1'b0, HSIZE_WORD, 32'h0);
        #1;
        check("t3_ready0", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        #1;
        check("t3_ready1", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        hready       = 1'b0;
        hrdata       = 32'hBAD0BAD0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_wait_haddr", haddr, 32'h204);
            check("t3_wait_htrans", htrans, HTRANS_NONSEQ);
            check("t3_wait_rsp", rsp_valid, 0);
            check("t3_wait_ready", req_ready, 0);
            step();
        end
        hready = 1'b1;
        hrdata = 32'hCAFE0001;
        #1;
        check("t3_rsp_valid", rsp_valid, 2'b01);
        check("t3_rsp_rdata", rsp_rdata, 32'hCAFE0001);
        step();
        hrdata = 32'h0204ABCD;
        #1;
        check("t3_rsp_next", rsp_valid, 2'b10);
        step();
        check("t3_rsp_done", rsp_valid, 0);
        check("t3_htrans_idle", htrans, HTRANS_IDLE);

        // ERROR on A while B is in address phase; B is replayed
        set_req(0, 1'b1, 32'h2F0, 1'b0, HSIZE_WORD, 32'h0);
        set_req(1, 1'b1, 32'h300, 1'b1, HSIZE_WORD, 32'hB0B0B0B0);
        #1;
        check("t4_ready_a", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        #1;
        check("t4_ready_b", req_ready, 2'b10);
        step();
        req_valid[1] = 1'b0;
        hready       = 1'b0;
        hresp        = 1'b1;
        #1;
        check("t4_err1_rsp", rsp_valid, 0);
        check("t4_err1_htrans", htrans, HTRANS_NONSEQ);
        check("t4_err1_haddr", haddr, 32'h300);
        step();
        hready = 1'b1;
        set_req(0, 1'b1, 32'h400, 1'b0, HSIZE_WORD, 32'h0);
        #1;
        check("t4_err2_htrans", htrans, HTRANS_IDLE);
        check("t4_err2_haddr", haddr, 32'h300);
        check("t4_err2_rsp", rsp_valid, 2'b01);
        check("t4_err2_err", rsp_err, 1);
        check("t4_err2_ready", req_ready, 0);
        step();
        hresp = 1'b0;
        #1;
        check("t4_replay_htrans", htrans, HTRANS_NONSEQ);
        check("t4_replay_haddr", haddr, 32'h300);
        check("t4_replay_hwrite", hwrite, 1);
        check("t4_replay_rsp", rsp_valid, 0);
        check("t4_ready_c", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        #1;
        check("t4_b_rsp", rsp_valid, 2'b10);
        check("t4_b_err", rsp_err, 0);
        check("t4_b_hwdata", hwdata, 32'hB0B0B0B0);
        check("t4_c_haddr", haddr, 32'h400);
        step();
        check("t4_c_rsp", rsp_valid, 2'b01);
        step();

        // Reset asserted while a write sits in data phase
        set_req(0, 1'b1, 32'h500, 1'b1, HSIZE_WORD, 32'h55);
        #1;
        check("t5_ready", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        step();
        hready = 1'b0;
        #1;
        check("t5_wait_rsp", rsp_valid, 0);
        hreset = 1'b1;
        #1;
        check("t5_rst_htrans", htrans, HTRANS_IDLE);
        check("t5_rst_haddr", haddr, 0);
        check("t5_rst_hwdata", hwdata, 0);
        check("t5_rst_hwrite", hwrite, 0);
        hready = 1'b1;
        #1;
        check("t5_rst_rsp", rsp_valid, 0);
        step();
        check("t5_rst_rsp_edge", rsp_valid, 0);
        hreset = 1'b0;
        set_req(0, 1'b1, 32'h600, 1'b0, HSIZE_WORD, 32'h0);
        set_req(1, 1'b1, 32'h604, 1'b0, HSIZE_WORD, 32'h0);
        #1;
        check("t5_first_winner", req_ready, 2'b01);
        req_valid = '0;
        #1;
        step();

        // Idle period leaves the pointer untouched
        for (int i = 0; i < 10; i++) begin
            check("t6_htrans", htrans, HTRANS_IDLE);
            check("t6_rsp", rsp_valid, 0);
            check("t6_ready", req_ready, 0);
            step();
        end
        req_valid = 2'b11;
        #1;
        check("t6_winner", req_ready, 2'b01);
        req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares one AHB-Lite master port between NREQ local requesters.
- Accepts single-transfer commands (NONSEQ/IDLE only, no bursts) with round-robin arbitration.
- Pipelines each command's address phase with the previous command's data phase.
- Returns read data and error status to the owning requester. Sits between on-chip command sources and the AHB interconnect.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 32, address width
DW, 32, data width

Ports:
hclk  in  1  bus clock
hreset  in  1  asynchronous active-high reset
req_valid  in  NREQ  requester i has a command
req_ready  out  NREQ  command of requester i accepted this cycle (combinational, one-hot or zero)
req_addr  in  NREQ*AW  flattened addresses, slice i = [i*AW +: AW]
req_write  in  NREQ  1=write
req_size  in  NREQ*3  flattened HSIZE codes
req_wdata  in  NREQ*DW  flattened write data
rsp_valid  out  NREQ  transfer of requester i completed this cycle (combinational)
rsp_rdata  out  DW  equals hrdata (shared by all requesters)
rsp_err  out  1  completing transfer received ERROR
haddr  out  AW  AHB address (registered)
htrans  out  2  AHB transfer type (registered)
hsize  out  3  AHB size (registered)
hwrite  out  1  AHB direction (registered)
hwdata  out  DW  AHB write data (registered)
hrdata  in  DW  AHB read data
hready  in  1  AHB ready
hresp  in  1  AHB response, 1=ERROR

Behaviour:
- Reset (asynchronous, active-high):
  - haddr=0, htrans=IDLE (2'b00), hsize=0, hwrite=0, hwdata=0.
  - Data-phase valid flag cleared; cancel flag cleared.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - In-flight transfers are dropped; no rsp_valid is produced for them.
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, searching from pointer+1 modulo NREQ.
  - req_ready[winner]=1 only when hready=1, cancel flag=0, and no error first cycle (hresp=0).
  - On an accepting edge, pointer <= winner.
- Address phase (registered, on hclk edges with hready=1):
  - If a winner exists: haddr/hsize/hwrite <= winner's fields, htrans <= NONSEQ (2'b10).
  - Otherwise: htrans <= IDLE; haddr/hsize/hwrite hold.
- Data phase:
  - On an hready=1 edge where htrans==NONSEQ, the address phase moves to data phase: dph_valid <= 1 and dph_owner <= current owner.
  - On the same edge, hwdata <= that command's wdata if hwrite=1, else hwdata holds.
  - If htrans==IDLE on that edge, dph_valid <= 0.
- Completion:
  - In any cycle with dph_valid=1 and hready=1: rsp_valid[dph_owner]=1 and rsp_err=hresp.
  - rsp_rdata always equals hrdata; meaningful for reads only.
- Latency:
  - Command accepted at edge N: address phase in cycle N..N+1; earliest rsp_valid in cycle N+1 (zero wait states).
  - Throughput is one transfer per cycle with back-to-back requests.
- Wait states: while hready=0, all AHB outputs, owner and pointer hold; req_ready=0; rsp_valid=0.
- Two-cycle ERROR (hresp=1, hready=0 with dph_valid=1):
  - If htrans==NONSEQ, next edge sets htrans=IDLE, keeps haddr/hsize/hwrite/wdata, and sets the cancel flag.
  - In the second error cycle (hresp=1, hready=1), the erroring transfer completes with rsp_err=1.
  - On that same edge the cancelled command is re-driven as NONSEQ with identical contents. No arbitration occurs on that edge; the cancel flag clears.
  - The cancelled command is not reported and is not re-accepted from the requester.
- Ordering: responses return in acceptance order; a requester may have two transfers in flight (one in address phase, one in data phase).
- A requester must hold req_* stable while req_valid=1 and req_ready=0; the block does not check this.
- Simultaneous events: completion of transfer A and acceptance of transfer B in the same cycle are legal and independent.

Decomposition:
- Package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HSIZE_BYTE/HALF/WORD constants.
  - HRESP_OKAY/ERROR constants.
- Sub-module ahb_rr_arbiter:
  - Inputs: NREQ request vector, pointer, enable.
  - Outputs: one-hot grant and binary winner index. Purely combinational.
  - The pointer register stays in the parent.

Test Plan:
- Reset then req0 write addr 0x100, size WORD, data 0xDEADBEEF, hready=1 -> req_ready[0] at edge 1; htrans=NONSEQ, haddr=0x100 in cycle 1; hwdata=0xDEADBEEF and rsp_valid[0]=1, rsp_err=0 in cycle 2.
- req0 and req1 reads held continuously, slave returns hrdata=0x11/0x22 -> grants alternate 0,1,0,1; four transfers in four consecutive cycles; rsp order matches grant order.
- Read addr 0x200 with hready low for 3 cycles in data phase, next command pending -> haddr/htrans hold 3 cycles; rsp_valid exactly once, with hrdata=0xCAFE0001.
- Slave gives ERROR on transfer A while transfer B (addr 0x300) is in address phase -> htrans=IDLE in error cycle 2; rsp_err=1 for A; B re-driven as NONSEQ 0x300 and completes OK; B's requester sees req_ready only once.
- Assert hreset mid-data-phase -> outputs immediately return to reset values; no rsp_valid; after release, requester 0 wins first.
- No requests for 10 cycles -> htrans stays IDLE, rsp_valid=0, pointer unchanged.
